// File: rtl/event_dispatcher.sv
// Event dispatcher: buffers DVS events, hands them one at a time to the graph core
// with per-window addresses, then captures the classification and clears the core.
package event_dispatcher_pkg;
  localparam int X_PIXEL_WIDTH = 8;
  localparam int Y_PIXEL_WIDTH = 8;
  localparam int T_WIDTH       = 32;

  typedef struct packed {
    logic                     valid;
    logic [X_PIXEL_WIDTH-1:0] x;
    logic [Y_PIXEL_WIDTH-1:0] y;
    logic                     p;
    logic [T_WIDTH-1:0]       t;
    logic [31:0]              addr;
  } event_s;

  typedef struct packed {
    logic [X_PIXEL_WIDTH-1:0] x;
    logic [Y_PIXEL_WIDTH-1:0] y;
    logic                     p;
    logic [T_WIDTH-1:0]       t;
  } fifo_ent_s;
endpackage

module event_dispatcher
  import event_dispatcher_pkg::*;
#(
  parameter int          FIFO_DEPTH    = 16,
  parameter int          WINDOW_EVENTS = 26,
  parameter logic [31:0] BASE_ADDR     = 32'h1000_0000,
  parameter logic [31:0] ADDR_STRIDE   = 32'h0000_0080,
  parameter int          DONE_TIMEOUT  = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [X_PIXEL_WIDTH-1:0] in_x,
  input  logic [Y_PIXEL_WIDTH-1:0] in_y,
  input  logic                     in_p,
  input  logic [T_WIDTH-1:0]       in_t,
  input  logic                     flush,
  output event_s                   new_event,
  output logic                     ip_en,
  input  logic                     ip_done,
  input  logic                     ip_idle,
  output logic                     ip_clean,
  input  logic                     ip_clear,
  input  logic                     prediction,
  input  logic [1:0][31:0]         fc_out_pack,
  output logic                     res_valid,
  output logic                     res_class,
  output logic [1:0][31:0]         res_logits,
  output logic                     timeout_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(WINDOW_EVENTS + 1);
  localparam int TW = $clog2(DONE_TIMEOUT + 1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_WIN  = IW'(WINDOW_EVENTS);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  localparam logic [TW-1:0] TMO_LAST = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_CAPTURE, S_CLEAN
  } state_e;

  fifo_ent_s        r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  state_e           r_state;
  event_s           r_event;
  logic [IW-1:0]    r_idx;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_flush_pending;
  logic             r_ip_en;
  logic             r_ip_clean;
  logic             r_res_valid;
  logic             r_res_class;
  logic [1:0][31:0] r_res_logits;
  logic             r_timeout_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_idx_zero;
  logic             w_flush_window;
  fifo_ent_s        w_head;
  logic [31:0]      w_addr;

  assign w_full         = (r_count == CNT_FULL);
  assign w_empty        = (r_count == '0);
  assign w_push         = in_valid & ~w_full;
  assign w_idx_zero     = (r_idx == '0);
  assign w_flush_window = r_flush_pending & ~w_idx_zero;
  // A pending flush with events in the window takes priority over the next dispatch.
  assign w_pop          = (r_state == S_IDLE) & ~w_flush_window & ~w_empty & ip_idle;
  assign w_head         = r_mem[r_rd_ptr];
  assign w_addr         = BASE_ADDR + ADDR_STRIDE * 32'(r_idx);

  // NOTE: the storage array carries no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= '{x: in_x, y: in_y, p: in_p, t: in_t};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: every state register here uses <= so all next-state terms read pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_event         <= '0;
      r_idx           <= '0;
      r_tmo_cnt       <= '0;
      r_flush_pending <= 1'b0;
      r_ip_en         <= 1'b0;
      r_ip_clean      <= 1'b0;
      r_res_valid     <= 1'b0;
      r_res_class     <= 1'b0;
      r_res_logits    <= '0;
      r_timeout_err   <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_flush_window) begin
            r_state <= S_CAPTURE;
          end else if (w_pop) begin
            r_state <= S_LOAD;
            r_event <= '{valid: 1'b1, x: w_head.x, y: w_head.y, p: w_head.p,
                         t: w_head.t, addr: w_addr};
          end
        end
        S_LOAD: begin
          r_state   <= S_RUN;
          r_ip_en   <= 1'b1;
          r_tmo_cnt <= '0;
        end
        S_RUN: begin
          if (ip_done || r_tmo_cnt == TMO_LAST) begin
            if (!ip_done) r_timeout_err <= 1'b1;
            r_ip_en       <= 1'b0;
            r_event.valid <= 1'b0;
            r_idx         <= r_idx + IDX_ONE;
            r_state       <= S_DRAIN;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
          end
        end
        S_DRAIN: begin
          if (!ip_done) begin
            r_state <= (r_idx == IDX_WIN || r_flush_pending) ? S_CAPTURE : S_IDLE;
          end
        end
        S_CAPTURE: begin
          r_res_class  <= prediction;
          r_res_logits <= fc_out_pack;
          r_res_valid  <= 1'b1;
          r_ip_clean   <= 1'b1;
          r_state      <= S_CLEAN;
        end
        S_CLEAN: begin
          if (ip_clear) begin
            r_ip_clean <= 1'b0;
            r_idx      <= '0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // A fresh flush request wins over any clear in the same cycle.
      if (flush) begin
        r_flush_pending <= 1'b1;
      end else if ((r_state == S_CLEAN && ip_clear) || (r_state == S_IDLE && w_idx_zero)) begin
        r_flush_pending <= 1'b0;
      end
    end
  end

  assign in_ready    = ~w_full;
  assign new_event   = r_event;
  assign ip_en       = r_ip_en;
  assign ip_clean    = r_ip_clean;
  assign res_valid   = r_res_valid;
  assign res_class   = r_res_class;
  assign res_logits  = r_res_logits;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_event_dispatcher.sv
// Directed bench for event_dispatcher: behavioural core responder plus a linear
// sequence of dispatch, window, backpressure, flush, timeout and reset scenarios.
module tb_event_dispatcher;
  import event_dispatcher_pkg::*;

  localparam logic [31:0] BASE   = 32'h1000_0000;
  localparam logic [31:0] STRIDE = 32'h0000_0080;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_x;
  logic [7:0]       in_y;
  logic             in_p;
  logic [31:0]      in_t;
  logic             flush;
  event_s           new_event;
  logic             ip_en;
  logic             ip_done;
  logic             ip_idle;
  logic             ip_clean;
  logic             ip_clear;
  logic             prediction;
  logic [1:0][31:0] fc_out_pack;
  logic             res_valid;
  logic             res_class;
  logic [1:0][31:0] res_logits;
  logic             timeout_err;

  int checks = 0;
  int errors = 0;

  bit  core_auto  = 1'b1;
  bit  clear_auto = 1'b1;
  int  done_delay = 20;

  event_s           disp_q[$];
  int               res_cnt    = 0;
  int               clean_cnt  = 0;
  int               stable_bad = 0;
  logic             last_class;
  logic [1:0][31:0] last_logits;

  event_dispatcher dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_p(in_p), .in_t(in_t), .flush(flush),
    .new_event(new_event), .ip_en(ip_en), .ip_done(ip_done), .ip_idle(ip_idle),
    .ip_clean(ip_clean), .ip_clear(ip_clear), .prediction(prediction),
    .fc_out_pack(fc_out_pack), .res_valid(res_valid), .res_class(res_class),
    .res_logits(res_logits), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core stand-in: raises ip_done done_delay cycles into ip_en, and ip_clear 3 cycles into ip_clean.
  task automatic core_model();
    int dcnt = 0;
    int ccnt = 0;
    forever begin
      @(negedge clk);
      if (ip_en && core_auto) begin
        if (!ip_done) begin
          dcnt++;
          if (dcnt >= done_delay) ip_done = 1'b1;
        end
      end else begin
        ip_done = 1'b0;
        dcnt    = 0;
      end
      if (ip_clean && clear_auto) begin
        ccnt++;
        if (ccnt >= 3) ip_clear = 1'b1;
      end else begin
        ip_clear = 1'b0;
        ccnt     = 0;
      end
    end
  endtask

  task automatic monitor();
    logic   prev_en    = 1'b0;
    logic   prev_clean = 1'b0;
    event_s prev_ev    = '0;
    forever begin
      @(negedge clk);
      if (ip_en && !prev_en) disp_q.push_back(new_event);
      if (ip_en && prev_en && new_event !== prev_ev) stable_bad++;
      if (res_valid) begin
        res_cnt++;
        last_class  = res_class;
        last_logits = res_logits;
      end
      if (ip_clean && !prev_clean) clean_cnt++;
      prev_en    = ip_en;
      prev_clean = ip_clean;
      prev_ev    = new_event;
    end
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] x, input logic [7:0] y, input logic p, input logic [31:0] t);
    int n = 0;
    in_x = x; in_y = y; in_p = p; in_t = t; in_valid = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("push_accept_in_budget", n < 300, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_disp_done(input int n);
    int c = 0;
    while (!(disp_q.size() >= n && ip_en === 1'b0) && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check("dispatch_in_budget", c < 3000, 1'b1);
    settle(3);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n;
    int k;
    int base_n;
    int res_before;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; in_p = 1'b0; in_t = '0;
    flush = 1'b0; ip_done = 1'b0; ip_idle = 1'b1; ip_clear = 1'b0;
    prediction = 1'b0; fc_out_pack = '0;
    fork
      core_model();
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ip_en", ip_en, 1'b0);
    check("rst_ip_clean", ip_clean, 1'b0);
    check("rst_new_event", new_event, '0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_class", res_class, 1'b0);
    check("rst_res_logits", res_logits, '0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Single event, 3-cycle dispatch latency, core done after 20 cycles.
    push(8'd10, 8'd10, 1'b1, 32'd0);
    @(negedge clk);
    check("lat_load_ip_en_low", ip_en, 1'b0);
    check("lat_load_valid", new_event.valid, 1'b1);
    @(negedge clk);
    check("lat_run_ip_en", ip_en, 1'b1);
    check("ev0_addr", new_event.addr, 32'h1000_0000);
    check("ev0_x", new_event.x, 8'd10);
    check("ev0_y", new_event.y, 8'd10);
    check("ev0_p", new_event.p, 1'b1);
    check("ev0_t", new_event.t, 32'd0);
    n = 0;
    while (ip_en === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("ev0_ip_en_cycles", n, 20);
    settle(6);
    check("ev0_no_res_valid", res_cnt, 0);
    check("ev0_no_clean", clean_cnt, 0);

    // Four more events (window idx 1..4), then flush ends the 5-event window.
    done_delay = 3;
    prediction = 1'b1;
    fc_out_pack = {32'hCAFE_0005, 32'h0000_0042};
    for (int i = 1; i <= 4; i++) push(8'(10 + i), 8'd10, 1'b0, 32'(i));
    wait_disp_done(5);
    for (int i = 1; i <= 4; i++) check("flushwin_addr", disp_q[i].addr, BASE + STRIDE * 32'(i));
    check("flushwin_no_res_yet", res_cnt, 0);
    pulse_flush();
    settle(12);
    check("flush5_res_cnt", res_cnt, 1);
    check("flush5_res_class", last_class, 1'b1);
    check("flush5_res_logits", last_logits, {32'hCAFE_0005, 32'h0000_0042});
    check("flush5_clean_cnt", clean_cnt, 1);
    check("flush5_clean_low", ip_clean, 1'b0);

    // Flush with an empty window must not capture or clean.
    pulse_flush();
    settle(10);
    check("flush0_no_res", res_cnt, 1);
    check("flush0_no_clean", clean_cnt, 1);

    // Full 26-event window: cross pattern around (10,10), addresses step by 0x80.
    prediction = 1'b0;
    fc_out_pack = {32'h8000_0001, 32'h7FFF_FFFE};
    base_n = disp_q.size();
    for (int i = 0; i < 26; i++) begin
      if (i < 13) push(8'(4 + i), 8'd10, 1'(i), 32'(i));
      else        push(8'd10, 8'(4 + i - 13), 1'(i), 32'(i));
    end
    wait_disp_done(base_n + 26);
    settle(12);
    for (int i = 0; i < 26; i++) begin
      check("win_addr", disp_q[base_n + i].addr, BASE + STRIDE * 32'(i));
      check("win_t", disp_q[base_n + i].t, 32'(i));
    end
    check("win_last_addr", disp_q[base_n + 25].addr, 32'h1000_0C80);
    check("win_res_cnt", res_cnt, 2);
    check("win_res_class", last_class, 1'b0);
    check("win_res_logits", last_logits, {32'h8000_0001, 32'h7FFF_FFFE});
    check("win_clean_cnt", clean_cnt, 2);
    push(8'd1, 8'd2, 1'b0, 32'd26);
    wait_disp_done(base_n + 27);
    check("win_next_addr", disp_q[base_n + 26].addr, 32'h1000_0000);

    // Core stalled: 16 accepted, then backpressure; no loss or reordering.
    ip_idle = 1'b0;
    base_n = disp_q.size();
    k = 0;
    in_t = 32'd100; in_x = 8'd3; in_y = 8'd4; in_p = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
        k++;
        in_t = 32'(100 + k);
      end
    end
    in_valid = 1'b0;
    check("stall_accepted", k, 16);
    check("stall_in_ready_low", in_ready, 1'b0);
    check("stall_no_dispatch", disp_q.size(), base_n);
    ip_idle = 1'b1;
    push(8'd3, 8'd4, 1'b1, 32'd116);
    push(8'd3, 8'd4, 1'b1, 32'd117);
    wait_disp_done(base_n + 18);
    for (int i = 0; i < 18; i++) check("stall_t_order", disp_q[base_n + i].t, 32'(100 + i));
    check("stall_in_ready_back", in_ready, 1'b1);

    // ip_done never arrives: timeout after exactly 4096 RUN cycles, then carry on.
    core_auto = 1'b0;
    base_n = disp_q.size();
    push(8'd5, 8'd5, 1'b0, 32'd200);
    n = 0;
    while (ip_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tmo_ip_en_rise", ip_en, 1'b1);
    n = 0;
    while (ip_en === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("tmo_run_cycles", n, 4096);
    check("tmo_err_set", timeout_err, 1'b1);
    check("tmo_ip_en_low", ip_en, 1'b0);
    core_auto = 1'b1;
    push(8'd5, 8'd6, 1'b0, 32'd201);
    wait_disp_done(base_n + 2);
    check("tmo_next_t", disp_q[base_n + 1].t, 32'd201);
    check("tmo_err_sticky", timeout_err, 1'b1);

    // Reset in RUN with a second event queued.
    done_delay = 50;
    push(8'd7, 8'd7, 1'b0, 32'd300);
    push(8'd7, 8'd8, 1'b0, 32'd301);
    settle(4);
    check("rstrun_in_run", ip_en, 1'b1);
    apply_reset();
    check("rstrun_ip_en", ip_en, 1'b0);
    check("rstrun_ip_clean", ip_clean, 1'b0);
    check("rstrun_in_ready", in_ready, 1'b1);
    check("rstrun_valid", new_event.valid, 1'b0);
    check("rstrun_timeout_err", timeout_err, 1'b0);
    rst = 1'b0;
    base_n = disp_q.size();
    settle(10);
    check("rstrun_fifo_empty", disp_q.size(), base_n);
    done_delay = 3;
    push(8'd9, 8'd9, 1'b0, 32'd302);
    wait_disp_done(base_n + 1);
    check("rstrun_idx_addr", disp_q[base_n].addr, 32'h1000_0000);

    // Reset in CLEAN while the core withholds ip_clear.
    clear_auto = 1'b0;
    res_before = res_cnt;
    pulse_flush();
    settle(6);
    check("rstclean_res", res_cnt, res_before + 1);
    check("rstclean_holding", ip_clean, 1'b1);
    apply_reset();
    check("rstclean_ip_clean", ip_clean, 1'b0);
    check("rstclean_ip_en", ip_en, 1'b0);
    check("rstclean_in_ready", in_ready, 1'b1);
    check("rstclean_res_valid", res_valid, 1'b0);
    rst = 1'b0;
    clear_auto = 1'b1;
    base_n = disp_q.size();
    push(8'd11, 8'd12, 1'b1, 32'd303);
    wait_disp_done(base_n + 1);
    check("rstclean_idx_addr", disp_q[base_n].addr, 32'h1000_0000);
    check("rstclean_clean_idle", ip_clean, 1'b0);
    check("new_event_stable_in_run", stable_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/event_dispatcher.md
Name: event_dispatcher

Overview:
- Upstream feeder for top_bd_wrapper: buffers a raw DVS event stream and assigns per-event graph-memory addresses.
- Drives new_event under the ip_en/ip_done handshake, one event at a time.
- After each window of events, captures the classification result, then issues ip_clean/ip_clear to reset graph state.
- Replaces the hand-sequenced stimulus currently used at the top_bd_wrapper boundary with synthesizable control logic.

Parameters:
- FIFO_DEPTH, 16, input event buffer depth (power of 2, >=2)
- WINDOW_EVENTS, 26, events per classification window before clean
- BASE_ADDR, 32'h1000_0000, address of event index 0
- ADDR_STRIDE, 32'h0000_0080, address increment per event index
- DONE_TIMEOUT, 4096, max cycles ip_en may wait for ip_done

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input event valid
- in_ready  out  1  input event accepted when in_valid & in_ready
- in_x  in  X_PIXEL_WIDTH  event x
- in_y  in  Y_PIXEL_WIDTH  event y
- in_p  in  1  polarity
- in_t  in  T_WIDTH  timestamp
- flush  in  1  single-cycle request to end the current window early
- new_event  out  event_s  event to core (valid, x, y, p, t, addr)
- ip_en  out  1  core start/enable
- ip_done  in  1  core finished current event
- ip_idle  in  1  core idle
- ip_clean  out  1  request core graph clear
- ip_clear  in  1  core clear complete
- prediction  in  1  core class output
- fc_out_pack  in  2x32  core logits
- res_valid  out  1  one-cycle pulse: result captured
- res_class  out  1  captured prediction
- res_logits  out  2x32  captured fc_out_pack
- timeout_err  out  1  sticky: ip_done not seen within DONE_TIMEOUT

Behaviour:
- Reset (rst=1 at a clk edge):
  - all outputs 0, including new_event.valid=0, ip_en=0, ip_clean=0, res_*=0, timeout_err=0.
  - FIFO emptied, event index=0, state IDLE.
  - Reset mid-handshake drops ip_en and ip_clean the next cycle with no completion.
- FIFO: in_ready = !full. Push on in_valid&in_ready. Pop only on IDLE->LOAD. A full FIFO deasserts in_ready; an empty FIFO blocks dispatch. Writes and reads in the same cycle are legal when not full.
- Address: new_event.addr = BASE_ADDR + idx*ADDR_STRIDE, 32-bit, wraps modulo 2^32. idx is the per-window event index, starting at 0; new_event.t = in_t unchanged.
- FSM:
  - IDLE: if flush_pending & idx>0 -> CAPTURE; elif FIFO non-empty & ip_idle -> LOAD (pop).
  - LOAD: register popped event into new_event with valid=1. Next cycle -> RUN.
  - RUN: ip_en=1; new_event held stable. ip_done sampled 1 -> ip_en=0 next cycle, idx++, -> DRAIN. Timeout counter increments each RUN cycle; reaching DONE_TIMEOUT sets timeout_err, drops ip_en, -> DRAIN (idx still increments).
  - DRAIN: wait ip_done=0. Then if idx==WINDOW_EVENTS or flush_pending -> CAPTURE, else -> IDLE.
  - CAPTURE: latch prediction/fc_out_pack into res_class/res_logits, pulse res_valid 1 cycle, -> CLEAN.
  - CLEAN: ip_clean=1 until ip_clear sampled 1. Then ip_clean=0, idx=0, clear flush_pending, -> IDLE.
- flush: sets flush_pending in any state. With idx==0 it clears itself without a capture.
- Inputs may keep filling the FIFO during CLEAN/CAPTURE.
- Minimum dispatch latency: event push to ip_en=1 is 3 cycles from an empty FIFO with the core idle.
- new_event is not updated while ip_en=1 or ip_clean=1.
- timeout_err clears only on rst.

Test Plan:
- Push 1 event (x=10,y=10,p=1,t=0); model ip_done 20 cycles after ip_en -> new_event.addr=0x1000_0000, ip_en high 20-21 cycles then low, idx=1, no res_valid.
- Push 26 events (t=0..25, the cross pattern around (10,10)) -> addrs 0x1000_0000..0x1000_0C80 step 0x80. After 26th done: res_valid pulse with res_logits equal to fc_out_pack at that cycle, then ip_clean high until ip_clear. The next event gets addr 0x1000_0000.
- Back-to-back push of FIFO_DEPTH+2 events with core stalled -> in_ready=0 after 16 accepted. No loss or reordering; t sequence exact on new_event.
- flush after 5 events -> CAPTURE/CLEAN after 5th done, idx reset. flush with idx=0 -> no res_valid, no ip_clean.
- ip_done never asserted -> timeout_err=1 after 4096 RUN cycles, ip_en=0, FSM continues with next event.
- rst asserted during RUN and during CLEAN -> next cycle ip_en=0, ip_clean=0, in_ready=1, FIFO empty, idx=0.
